// File: rtl/lsu_mem_port_pkg.sv
// Shared definitions for the load/store unit memory port.
//   - MemOp (func3) codes for byte/half/word, signed and unsigned loads
//   - FSM state encoding used by lsu_mem_port
//   - lsu_op_err(): alignment / legality check applied when a request is accepted
package lsu_mem_port_pkg;

  localparam logic [2:0] MOP_B  = 3'b000;
  localparam logic [2:0] MOP_H  = 3'b001;
  localparam logic [2:0] MOP_W  = 3'b010;
  localparam logic [2:0] MOP_BU = 3'b100;
  localparam logic [2:0] MOP_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  // Unsigned variants exist only for loads, so a store with BU/HU is illegal.
  function automatic logic lsu_op_err(input logic [2:0] op,
                                      input logic [1:0] a,
                                      input logic       is_store);
    logic err;
    case (op)
      MOP_B:   err = 1'b0;
      MOP_H:   err = a[0];
      MOP_W:   err = (a != 2'b00);
      MOP_BU:  err = is_store;
      MOP_HU:  err = is_store | a[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load data alignment and extension (purely combinational).
// Shifts the addressed byte/half down to bit 0 of the bus word and
// sign- or zero-extends it according to MemOp.
//   i_memop  in   3   MemOp of the load
//   i_shift  in   2   byte offset within the word (addr[1:0])
//   i_rdata  in   32  raw word from the data bus
//   o_data   out  32  extended load result
module lsu_load_ext
  import lsu_mem_port_pkg::*;
(
  input  logic [2:0]  i_memop,
  input  logic [1:0]  i_shift,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_shift, 3'b000};

  always_comb begin
    o_data = w_shifted;
    case (i_memop)
      MOP_B:   o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      MOP_H:   o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      MOP_BU:  o_data = {24'd0, w_shifted[7:0]};
      MOP_HU:  o_data = {16'd0, w_shifted[15:0]};
      default: o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit between the execute stage and a single-beat data bus.
// Accepts one request at a time (valid/ready), drives byte strobes and
// lane-replicated store data, and returns extended load data with a
// one-cycle out_valid pulse. Illegal/misaligned requests and read
// timeouts complete with out_err and never touch the bus.
//   clk, rst                         clock, synchronous active-high reset
//   in_valid/in_ready                request handshake from execute stage
//   in_memwr, in_memrd, in_memop     control word (store wins if both set)
//   in_addr, in_wdata                byte address and store data
//   out_valid, out_rdata, out_err    completion pulse, load data, error flag
//   mem_valid/mem_ready              bus request handshake
//   mem_wen, mem_addr, mem_wdata,
//   mem_wmask                        bus request payload (word-aligned)
//   mem_rvalid, mem_rdata            bus read response
//
// state | meaning
// IDLE  | ready for a new request
// REQ   | bus request held until mem_ready
// WAIT  | load issued, waiting for mem_rvalid (optionally bounded)
// DONE  | one-cycle completion pulse
module lsu_mem_port
  import lsu_mem_port_pkg::*;
#(
  parameter int TIMEOUT = 0,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_memwr,
  input  logic          in_memrd,
  input  logic [2:0]    in_memop,
  input  logic [AW-1:0] in_addr,
  input  logic [31:0]   in_wdata,
  output logic          out_valid,
  output logic [31:0]   out_rdata,
  output logic          out_err,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wmask,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata
);

  localparam logic [31:0] TO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  lsu_state_e    r_state, w_next;
  logic          r_store;
  logic [2:0]    r_op;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic          r_err;
  logic [31:0]   r_rdata;
  logic [31:0]   r_tcnt;

  logic          w_accept;
  logic          w_acc_err;
  logic          w_timeout;
  logic [31:0]   w_ext;
  logic [3:0]    w_wmask;
  logic [31:0]   w_wdata;

  assign w_acc_err = lsu_op_err(in_memop, in_addr[1:0], in_memwr);

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid && (in_memwr || in_memrd)) begin
          w_accept = 1'b1;
          w_next   = w_acc_err ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_ready) w_next = r_store ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        // A response arriving on the last allowed cycle still wins.
        if (mem_rvalid) begin
          w_next = ST_DONE;
        end else if ((TIMEOUT != 0) && (r_tcnt == TO_LAST)) begin
          w_timeout = 1'b1;
          w_next    = ST_DONE;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_store <= 1'b0;
      r_op    <= 3'd0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
      r_tcnt  <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_store <= in_memwr;
        r_op    <= in_memop;
        r_addr  <= in_addr;
        r_wdata <= in_wdata;
        r_err   <= w_acc_err;
        r_rdata <= 32'd0;
      end
      if ((r_state == ST_REQ) && mem_ready) r_tcnt <= 32'd0;
      if (r_state == ST_WAIT) begin
        r_tcnt <= r_tcnt + 32'd1;
        if (mem_rvalid) r_rdata <= w_ext;
      end
      if (w_timeout) r_err <= 1'b1;
    end
  end

  lsu_load_ext u_load_ext (
    .i_memop (r_op),
    .i_shift (r_addr[1:0]),
    .i_rdata (mem_rdata),
    .o_data  (w_ext)
  );

  always_comb begin
    w_wmask = 4'b1111;
    w_wdata = r_wdata;
    case (r_op[1:0])
      2'b00: begin
        w_wmask = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_wmask = 4'b0011 << r_addr[1:0];
        w_wdata = {2{r_wdata[15:0]}};
      end
      default: begin
        w_wmask = 4'b1111;
        w_wdata = r_wdata;
      end
    endcase
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign out_err   = (r_state == ST_DONE) && r_err;
  assign out_rdata = (r_state == ST_DONE) ? r_rdata : 32'd0;
  assign mem_valid = (r_state == ST_REQ);
  assign mem_wen   = (r_state == ST_REQ) && r_store;
  assign mem_wmask = ((r_state == ST_REQ) && r_store) ? w_wmask : 4'b0000;
  assign mem_addr  = {r_addr[AW-1:2], 2'b00};
  assign mem_wdata = w_wdata;

endmodule

// File: tb/tb_lsu_mem_port.sv
module tb_lsu_mem_port;

  localparam int TO = 4;
  localparam logic [2:0] OP_B = 3'b000, OP_H = 3'b001, OP_W = 3'b010,
                         OP_BU = 3'b100, OP_HU = 3'b101, OP_X = 3'b011;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_memwr, in_memrd;
  logic [2:0]  in_memop;
  logic [31:0] in_addr, in_wdata;
  logic        out_valid, out_err;
  logic [31:0] out_rdata;
  logic        mem_valid, mem_ready, mem_wen, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  always #5 clk = ~clk;

  lsu_mem_port #(.TIMEOUT(TO), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_memwr(in_memwr), .in_memrd(in_memrd),
    .in_memop(in_memop), .in_addr(in_addr), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_rdata(out_rdata), .out_err(out_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  logic chk_en = 1'b0;

  logic        exp_in_ready, exp_out_valid, exp_out_err, exp_mem_valid, exp_mem_wen;
  logic [31:0] exp_out_rdata, exp_mem_addr, exp_mem_wdata;
  logic [3:0]  exp_mem_wmask;

  int          seen_valid_cnt, seen_mv_cnt, seen_done_cyc;
  logic        seen_err;
  logic [31:0] seen_rdata, seen_addr, seen_wdata;
  logic [3:0]  seen_wmask;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the expectations the stimulus sets up.
  always @(negedge clk) begin
    if (chk_en) begin
      check32("in_ready", 32'(in_ready), 32'(exp_in_ready));
      check32("out_valid", 32'(out_valid), 32'(exp_out_valid));
      check32("mem_valid", 32'(mem_valid), 32'(exp_mem_valid));
      check32("mem_wen", 32'(mem_wen), 32'(exp_mem_wen));
      check32("mem_wmask", 32'(mem_wmask), 32'(exp_mem_wmask));
      if (exp_out_valid) begin
        check32("out_err", 32'(out_err), 32'(exp_out_err));
        check32("out_rdata", out_rdata, exp_out_rdata);
      end
      if (exp_mem_valid) check32("mem_addr", mem_addr, exp_mem_addr);
      if (exp_mem_valid && exp_mem_wen) check32("mem_wdata", mem_wdata, exp_mem_wdata);
    end
  end

  // Observation of what the DUT did, for the literal per-transaction checks.
  always @(negedge clk) begin
    if (out_valid) begin
      seen_valid_cnt++;
      seen_done_cyc = cyc;
      seen_err      = out_err;
      seen_rdata    = out_rdata;
    end
    if (mem_valid) begin
      seen_mv_cnt++;
      seen_addr  = mem_addr;
      seen_wdata = mem_wdata;
      seen_wmask = mem_wmask;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- behavioural model ----------------
  function automatic int m_size(input logic [2:0] op);
    if (op[1:0] == 2'b00) return 1;
    if (op[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic m_err(input logic [2:0] op, input logic [31:0] addr, input logic st);
    if (op == 3'b011 || op == 3'b110 || op == 3'b111) return 1'b1;
    if (st && op[2]) return 1'b1;
    return (int'(addr[1:0]) % m_size(op)) != 0;
  endfunction

  function automatic logic [3:0] m_mask(input logic [2:0] op, input logic [31:0] addr);
    logic [3:0] m;
    int s, sz;
    s = int'(addr[1:0]);
    sz = m_size(op);
    m = 4'b0;
    for (int i = 0; i < 4; i++) if (i >= s && i < s + sz) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] wd);
    logic [31:0] r;
    int sz;
    sz = m_size(op);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] addr,
                                         input logic [31:0] rd);
    logic [63:0] u;
    int sz, s;
    sz = m_size(op);
    s = int'(addr[1:0]);
    u = {32'd0, rd} >> (8 * s);
    u = u & ((64'd1 << (8 * sz)) - 64'd1);
    if (!op[2] && sz < 4 && u[8*sz-1]) u = u - (64'd1 << (8 * sz));
    return u[31:0];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_idle_exp();
    exp_in_ready = 1'b1; exp_out_valid = 1'b0; exp_out_err = 1'b0; exp_out_rdata = 32'd0;
    exp_mem_valid = 1'b0; exp_mem_wen = 1'b0; exp_mem_wmask = 4'b0;
    exp_mem_addr = 32'd0; exp_mem_wdata = 32'd0;
  endtask

  task automatic set_busy_exp();
    set_idle_exp();
    exp_in_ready = 1'b0;
  endtask

  // rv_dly: WAIT cycle index carrying mem_rvalid (-1 = never).
  // noise: pulse mem_rvalid with junk data while the request is in REQ.
  task automatic txn(input logic st, input logic ld, input logic [2:0] op,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input int rdy_dly, input int rv_dly, input logic [31:0] rdata,
                     input logic noise);
    logic e, done;
    e = m_err(op, addr, st);
    cyc = 0;
    seen_valid_cnt = 0; seen_mv_cnt = 0; seen_done_cyc = -1; seen_err = 1'b0;
    seen_rdata = 32'hx; seen_wmask = 4'hx; seen_wdata = 32'hx; seen_addr = 32'hx;
    in_valid = 1'b1; in_memwr = st; in_memrd = ld; in_memop = op;
    in_addr = addr; in_wdata = wdata;
    set_idle_exp();
    step();
    in_valid = 1'b0; in_memwr = 1'b0; in_memrd = 1'b0; in_memop = 3'b111;
    in_addr = ~addr; in_wdata = ~wdata;
    if (!e) begin
      set_busy_exp();
      exp_mem_valid = 1'b1;
      exp_mem_wen   = st;
      exp_mem_wmask = st ? m_mask(op, addr) : 4'b0;
      exp_mem_addr  = {addr[31:2], 2'b00};
      exp_mem_wdata = m_wdata(op, wdata);
      for (int k = 0; k <= rdy_dly; k++) begin
        mem_ready = (k == rdy_dly);
        if (noise) begin
          mem_rvalid = 1'b1;
          mem_rdata = 32'h5A5A_0000 ^ k;
        end
        step();
      end
      mem_ready = 1'b0; mem_rvalid = 1'b0;
      set_busy_exp();
      if (!st) begin
        done = 1'b0;
        for (int w = 0; w < TO && !done; w++) begin
          if (w == rv_dly) begin
            mem_rvalid = 1'b1;
            mem_rdata = rdata;
            done = 1'b1;
          end
          step();
          mem_rvalid = 1'b0;
          mem_rdata = 32'hBAD0_BAD0;
        end
        if (!done) e = 1'b1;
      end
    end
    set_busy_exp();
    exp_out_valid = 1'b1;
    exp_out_err   = e;
    exp_out_rdata = (e || st) ? 32'd0 : m_load(op, addr, rdata);
    step();
    set_idle_exp();
    step();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_memwr = 1'b0; in_memrd = 1'b0; in_memop = 3'd0;
    in_addr = 32'd0; in_wdata = 32'd0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    set_idle_exp();
    step();
    chk_en = 1'b1;
    step();
    check32("rst_in_ready", 32'(in_ready), 32'd1);
    check32("rst_out_valid", 32'(out_valid), 32'd0);
    check32("rst_out_err", 32'(out_err), 32'd0);
    check32("rst_out_rdata", out_rdata, 32'd0);
    check32("rst_mem_valid", 32'(mem_valid), 32'd0);
    check32("rst_mem_wmask", 32'(mem_wmask), 32'd0);
    rst = 1'b0;
    step();

    // SW, zero-wait bus
    txn(1, 0, OP_W, 32'h100, 32'hDEADBEEF, 0, 0, 32'd0, 0);
    check32("sw_done_cycle", 32'(seen_done_cyc), 32'd2);
    check32("sw_pulses", 32'(seen_valid_cnt), 32'd1);
    check32("sw_wmask", 32'(seen_wmask), 32'hF);
    check32("sw_addr", seen_addr, 32'h100);
    check32("sw_wdata", seen_wdata, 32'hDEADBEEF);
    check32("sw_err", 32'(seen_err), 32'd0);

    // SB to the top byte lane
    txn(1, 0, OP_B, 32'h103, 32'h000000A5, 0, 0, 32'd0, 0);
    check32("sb_wmask", 32'(seen_wmask), 32'h8);
    check32("sb_wdata", seen_wdata, 32'hA5A5A5A5);
    check32("sb_addr", seen_addr, 32'h100);

    // Loads
    txn(0, 1, OP_B, 32'h102, 32'd0, 0, 0, 32'h00800000, 0);
    check32("lb_rdata", seen_rdata, 32'hFFFFFF80);
    check32("lb_done_cycle", 32'(seen_done_cyc), 32'd3);
    txn(0, 1, OP_BU, 32'h102, 32'd0, 0, 0, 32'h00800000, 0);
    check32("lbu_rdata", seen_rdata, 32'h00000080);
    txn(0, 1, OP_HU, 32'h102, 32'd0, 0, 0, 32'h80010000, 0);
    check32("lhu_rdata", seen_rdata, 32'h00008001);
    txn(0, 1, OP_H, 32'h102, 32'd0, 0, 0, 32'h80010000, 0);
    check32("lh_rdata", seen_rdata, 32'hFFFF8001);
    txn(0, 1, OP_W, 32'h104, 32'd0, 0, 0, 32'h12345678, 1);
    check32("lw_noise_rdata", seen_rdata, 32'h12345678);
    txn(0, 1, OP_B, 32'h101, 32'd0, 0, 1, 32'h0000FE00, 0);
    txn(1, 0, OP_H, 32'h102, 32'h0000BEEF, 1, 0, 32'd0, 0);
    check32("sh_wmask", 32'(seen_wmask), 32'hC);
    check32("sh_wdata", seen_wdata, 32'hBEEFBEEF);

    // Errors: no bus traffic, completion one cycle after accept
    txn(0, 1, OP_W, 32'h101, 32'd0, 0, 0, 32'd0, 0);
    check32("lw_mis_err", 32'(seen_err), 32'd1);
    check32("lw_mis_done_cycle", 32'(seen_done_cyc), 32'd1);
    check32("lw_mis_no_bus", 32'(seen_mv_cnt), 32'd0);
    txn(0, 1, OP_X, 32'h100, 32'd0, 0, 0, 32'd0, 0);
    check32("op011_err", 32'(seen_err), 32'd1);
    check32("op011_no_bus", 32'(seen_mv_cnt), 32'd0);
    txn(1, 0, OP_BU, 32'h100, 32'h11, 0, 0, 32'd0, 0);
    check32("sbu_err", 32'(seen_err), 32'd1);
    txn(1, 0, OP_H, 32'h101, 32'h11, 0, 0, 32'd0, 0);
    check32("sh_mis_err", 32'(seen_err), 32'd1);

    // Store and load flags together: handled as a store
    txn(1, 1, OP_W, 32'h208, 32'hCAFEF00D, 0, 0, 32'd0, 0);
    check32("wr_rd_wen_pulses", 32'(seen_valid_cnt), 32'd1);

    // Stalled bus: REQ held 6 cycles, response on the last allowed WAIT cycle
    txn(0, 1, OP_W, 32'h300, 32'd0, 5, 3, 32'h0BADCAFE, 0);
    check32("stall_done_cycle", 32'(seen_done_cyc), 32'd11);
    check32("stall_pulses", 32'(seen_valid_cnt), 32'd1);
    check32("stall_rdata", seen_rdata, 32'h0BADCAFE);

    // Timeout: no response at all
    txn(0, 1, OP_W, 32'h300, 32'd0, 0, -1, 32'd0, 0);
    check32("timeout_err", 32'(seen_err), 32'd1);
    check32("timeout_done_cycle", 32'(seen_done_cyc), 32'd6);
    check32("timeout_rdata", seen_rdata, 32'd0);

    // in_valid with neither MemWr nor MemtoReg is not consumed
    set_idle_exp();
    in_valid = 1'b1; in_memwr = 1'b0; in_memrd = 1'b0; in_memop = OP_W; in_addr = 32'h400;
    step();
    step();
    check32("nop_not_taken", 32'(in_ready), 32'd1);
    in_valid = 1'b0;

    // Reset while waiting for a read response
    seen_valid_cnt = 0;
    in_valid = 1'b1; in_memrd = 1'b1; in_memop = OP_W; in_addr = 32'h200;
    set_idle_exp();
    step();
    in_valid = 1'b0; in_memrd = 1'b0;
    set_busy_exp();
    exp_mem_valid = 1'b1; exp_mem_addr = 32'h200;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    set_busy_exp();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_idle_exp();
    check32("rst_wait_in_ready", 32'(in_ready), 32'd1);
    check32("rst_wait_mem_valid", 32'(mem_valid), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h77777777;
    repeat (3) step();
    mem_rvalid = 1'b0;
    step();
    check32("rst_wait_no_pulse", 32'(seen_valid_cnt), 32'd0);

    // Recovery after reset
    txn(1, 0, OP_B, 32'h501, 32'h0000003C, 0, 0, 32'd0, 0);
    check32("recover_wmask", 32'(seen_wmask), 32'h2);
    check32("recover_wdata", seen_wdata, 32'h3C3C3C3C);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
